// File: rtl/window_3x3_gen.sv
// window_3x3_gen: streaming 3x3 neighbourhood generator feeding the blur stage.
// Keeps two previous image rows in line buffers and shifts a 3x3 window one
// column per accepted pixel. A window is emitted only when it lies entirely
// inside the frame (x>=2, y>=2).
// Handshake: a pixel is accepted on a rising edge when pixel_valid_in and
// ready_out are both high; ready_out is simply !busy_in, and a pixel offered
// while not ready is not consumed and must be held by the source.
// Optional feature macro: WINDOW_GEN_ERROR_EN (sticky flag on valid-while-busy).
module window_3x3_gen #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [WIDTH-1:0]     pixel_in,
  input  logic                 pixel_valid_in,
  output logic                 ready_out,
  input  logic                 busy_in,
  output logic [3*WIDTH-1:0]   r0_data_out,
  output logic [3*WIDTH-1:0]   r1_data_out,
  output logic [3*WIDTH-1:0]   r2_data_out,
  output logic                 data_valid_out,
  output logic                 frame_done_out,
  output logic                 error_out
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_TWO  = XW'(2);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);

  logic                accept;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [WIDTH-1:0]    lb0_q [IMG_W];  // row y-2
  logic [WIDTH-1:0]    lb1_q [IMG_W];  // row y-1
  logic [WIDTH-1:0]    l0_rd, l1_rd;
  logic [3*WIDTH-1:0]  win0_q, win0_d;
  logic [3*WIDTH-1:0]  win1_q, win1_d;
  logic [3*WIDTH-1:0]  win2_q, win2_d;
  logic                emit, last_px;
  logic                dv_q, done_q;

  assign ready_out = !busy_in;
  assign accept    = pixel_valid_in && !busy_in;
  assign l0_rd     = lb0_q[x_q];
  assign l1_rd     = lb1_q[x_q];
  assign emit      = accept && (x_q >= X_TWO) && (y_q >= Y_TWO);
  assign last_px   = accept && (x_q == X_LAST) && (y_q == Y_LAST);

  // Next-state for raster position and window shift; everything holds on non-accept cycles.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    win0_d = win0_q;
    win1_d = win1_q;
    win2_d = win2_q;
    if (accept) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
      win0_d = {win0_q[2*WIDTH-1:0], l0_rd};
      win1_d = {win1_q[2*WIDTH-1:0], l1_rd};
      win2_d = {win2_q[2*WIDTH-1:0], pixel_in};
    end
  end

  // Position counters, window registers and output pulses, cleared by reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      x_q    <= '0;
      y_q    <= '0;
      win0_q <= '0;
      win1_q <= '0;
      win2_q <= '0;
      dv_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      win0_q <= win0_d;
      win1_q <= win1_d;
      win2_q <= win2_d;
      dv_q   <= emit;
      done_q <= last_px;
    end
  end

  // Line buffers: no reset (stale rows are never emitted because y>=2 gates output).
  always_ff @(posedge clk_in) begin
    if (rst_in && accept) begin
      lb0_q[x_q] <= l1_rd;
      lb1_q[x_q] <= pixel_in;
    end
  end

  assign r0_data_out    = win0_q;
  assign r1_data_out    = win1_q;
  assign r2_data_out    = win2_q;
  assign data_valid_out = dv_q;
  assign frame_done_out = done_q;

`ifdef WINDOW_GEN_ERROR_EN
  logic err_q;

  // Sticky flag: source offered a pixel while downstream was busy.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      err_q <= 1'b0;
    end else if (pixel_valid_in && busy_in) begin
      err_q <= 1'b1;
    end
  end

  assign error_out = err_q;
`else
  assign error_out = 1'b0;
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen at IMG_W=IMG_H=4, WIDTH=8: hand-derived vector
// table for one frame with a stall, scoreboard model for the remaining runs.
module tb_window_3x3_gen;

  localparam int WIDTH = 8;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int RW    = 3 * WIDTH;

  logic            clk;
  logic            rst_in;
  logic [WIDTH-1:0] pixel_in;
  logic            pixel_valid_in;
  logic            ready_out;
  logic            busy_in;
  logic [RW-1:0]   r0_data_out, r1_data_out, r2_data_out;
  logic            data_valid_out;
  logic            frame_done_out;
  logic            error_out;

  window_3x3_gen #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .pixel_in       (pixel_in),
    .pixel_valid_in (pixel_valid_in),
    .ready_out      (ready_out),
    .busy_in        (busy_in),
    .r0_data_out    (r0_data_out),
    .r1_data_out    (r1_data_out),
    .r2_data_out    (r2_data_out),
    .data_valid_out (data_valid_out),
    .frame_done_out (frame_done_out),
    .error_out      (error_out)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pix;
    logic        valid;
    logic        busy;
    logic        exp_dv;
    logic        exp_done;
    logic [23:0] r0;
    logic [23:0] r1;
    logic [23:0] r2;
  } vec_t;

  vec_t tbl[19];

  // Scoreboard and reference model state
  logic [3*RW-1:0] exp_q[$];
  int              n_cmp;
  int              n_err;
  logic [7:0]      img[IMG_H][IMG_W];
  int              mx, my;
  logic            exp_err;
  logic [3*RW-1:0] exp_last;
  bit              last_ok;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx       = 0;
    my       = 0;
    exp_err  = 1'b0;
    exp_last = '0;
    last_ok  = 1'b1;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_in         = 1'b0;
    pixel_valid_in = 1'b0;
    busy_in        = 1'b0;
    pixel_in       = '0;
    @(posedge clk);
    #1;
    model_reset();
    check("rst_rows", 72'({r0_data_out, r1_data_out, r2_data_out}), 72'd0);
    check("rst_dv", 72'(data_valid_out), 72'd0);
    check("rst_done", 72'(frame_done_out), 72'd0);
    check("rst_err", 72'(error_out), 72'd0);
    rst_in = 1'b1;
  endtask

  // Driver: one clock of stimulus; the model predicts, the scoreboard compares.
  task automatic step(input logic [7:0] pix, input logic valid, input logic busy);
    logic            acc;
    logic            exp_dv, exp_done;
    logic [3*RW-1:0] win, got;
    pixel_in       = pix;
    pixel_valid_in = valid;
    busy_in        = busy;
    #1;
    check("ready", 72'(ready_out), 72'(!busy));
    acc      = valid && !busy;
    exp_dv   = 1'b0;
    exp_done = 1'b0;
`ifdef WINDOW_GEN_ERROR_EN
    if (valid && busy) exp_err = 1'b1;
`endif
    if (acc) begin
      img[my][mx] = pix;
      if (mx >= 2 && my >= 2) begin
        win = {img[my-2][mx-2], img[my-2][mx-1], img[my-2][mx],
               img[my-1][mx-2], img[my-1][mx-1], img[my-1][mx],
               img[my][mx-2],   img[my][mx-1],   img[my][mx]};
        exp_q.push_back(win);
        exp_dv   = 1'b1;
        exp_last = win;
        last_ok  = 1'b1;
      end else begin
        last_ok = 1'b0;
      end
      exp_done = (mx == IMG_W - 1) && (my == IMG_H - 1);
      if (mx == IMG_W - 1) begin
        mx = 0;
        my = (my == IMG_H - 1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
    end
    @(posedge clk);
    #1;
    check("dv", 72'(data_valid_out), 72'(exp_dv));
    check("done", 72'(frame_done_out), 72'(exp_done));
    check("err", 72'(error_out), 72'(exp_err));
    got = {r0_data_out, r1_data_out, r2_data_out};
    if (data_valid_out) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_window: got %0h expected no window", got);
      end else begin
        win = exp_q.pop_front();
        check("sb_window", 72'(got), 72'(win));
      end
    end else if (!acc && last_ok) begin
      check("hold", 72'(got), 72'(exp_last));
    end
    pixel_valid_in = 1'b0;
    busy_in        = 1'b0;
  endtask

  task automatic run_table();
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].pix, tbl[i].valid, tbl[i].busy);
      check($sformatf("tbl_dv[%0d]", i), 72'(data_valid_out), 72'(tbl[i].exp_dv));
      check($sformatf("tbl_done[%0d]", i), 72'(frame_done_out), 72'(tbl[i].exp_done));
      if (tbl[i].exp_dv) begin
        check($sformatf("tbl_r0[%0d]", i), 72'(r0_data_out), 72'(tbl[i].r0));
        check($sformatf("tbl_r1[%0d]", i), 72'(r1_data_out), 72'(tbl[i].r1));
        check($sformatf("tbl_r2[%0d]", i), 72'(r2_data_out), 72'(tbl[i].r2));
      end
    end
  endtask

  initial begin
    int k;
    int accepted;
    int iters;
    logic [7:0] rp;
    logic       rv, rb;

    n_cmp = 0;
    n_err = 0;
    model_reset();

    // Frame 0x01..0x10 with a 3-cycle stall holding 0x0C.
    k = 0;
    for (int p = 1; p <= 16; p++) begin
      if (p == 12) begin
        for (int s = 0; s < 3; s++) begin
          tbl[k] = '{8'h0C, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 24'h0, 24'h0};
          k++;
        end
      end
      tbl[k] = '{8'(p), 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 24'h0};
      k++;
    end
    tbl[10] = '{8'h0B, 1'b1, 1'b0, 1'b1, 1'b0, 24'h010203, 24'h050607, 24'h090A0B};
    tbl[14] = '{8'h0C, 1'b1, 1'b0, 1'b1, 1'b0, 24'h020304, 24'h060708, 24'h0A0B0C};
    tbl[17] = '{8'h0F, 1'b1, 1'b0, 1'b1, 1'b0, 24'h050607, 24'h090A0B, 24'h0D0E0F};
    tbl[18] = '{8'h10, 1'b1, 1'b0, 1'b1, 1'b1, 24'h060708, 24'h0A0B0C, 24'h0E0F10};

    do_reset();
    run_table();

    // Second frame directly after the first.
    for (int p = 8'h11; p <= 8'h20; p++) begin
      step(8'(p), 1'b1, 1'b0);
      if (p == 8'h1B)
        check("f2_first", 72'({r0_data_out, r1_data_out, r2_data_out}),
              72'h111213_151617_191A1B);
    end

    // Reset after 6 pixels, then the first frame again.
    for (int p = 8'h31; p <= 8'h36; p++) step(8'(p), 1'b1, 1'b0);
    do_reset();
    run_table();

    // Random frame with random gaps and backpressure.
    accepted = 0;
    iters    = 0;
    while (accepted < IMG_W * IMG_H && iters < 500) begin
      rp = 8'($urandom_range(0, 255));
      rv = ($urandom_range(0, 3) != 0);
      rb = ($urandom_range(0, 3) == 0);
      step(rp, rv, rb);
      if (rv && !rb) accepted++;
      iters++;
    end
    check("rand_accepts", 72'(accepted), 72'(IMG_W * IMG_H));

    // Valid while busy: error flag behaviour, sticky until reset.
    do_reset();
    step(8'h55, 1'b1, 1'b1);
`ifdef WINDOW_GEN_ERROR_EN
    check("err_set", 72'(error_out), 72'd1);
`else
    check("err_set", 72'(error_out), 72'd0);
`endif
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b0);
    do_reset();

    check("queue_empty", 72'(exp_q.size()), 72'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
